// File: rtl/instr_encoder.sv
// Packs decoded RV32IM fields and a sign-extended immediate into instruction words and
// streams them as sequential writes into instruction memory (program loader).
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 64,
   localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          restart,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [6:0]    opcode,
   input  logic [4:0]    rd,
   input  logic [4:0]    rs1,
   input  logic [4:0]    rs2,
   input  logic [2:0]    funct3,
   input  logic          funct7b0,
   input  logic          funct7b5,
   input  logic [31:0]   imm,
   output logic          wr_valid,
   input  logic          mem_ready,
   output logic [31:0]   wr_addr,
   output logic [31:0]   wr_data,
   output logic          err,
   output logic          done,
   output logic [CW-1:0] count
);

   typedef enum logic {StLoad, StFull} state_e;

   state_e        r_state,    w_state_nxt;
   logic          r_wr_valid, w_wr_valid_nxt;
   logic [31:0]   r_wr_data,  w_wr_data_nxt;
   logic [31:0]   r_addr,     w_addr_nxt;
   logic [CW-1:0] r_count,    w_count_nxt;
   logic          r_err,      w_err_nxt;

   logic          w_accept;
   logic          w_wr_done;
   logic          w_last_slot;
   logic          w_legal;
   logic [31:0]   w_word;
   logic          w_imm_i_ok;
   logic          w_imm_sh_ok;
   logic          w_imm_b_ok;
   logic          w_imm_j_ok;
   logic          w_imm_u_ok;

   // ---------------------------------------------------------------------------------------
   // Field packing and immediate range checks
   // ---------------------------------------------------------------------------------------
   assign w_imm_i_ok  = (&imm[31:11]) | ~(|imm[31:11]);
   assign w_imm_sh_ok = ~(|imm[31:5]);
   assign w_imm_b_ok  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
   assign w_imm_j_ok  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
   assign w_imm_u_ok  = ~(|imm[11:0]);

   always_comb begin
      w_word  = 32'h0;
      w_legal = 1'b0;
      case (opcode)
         7'b0110011: begin
            w_word  = {1'b0, funct7b5, 4'b0, funct7b0, rs2, rs1, funct3, rd, opcode};
            w_legal = 1'b1;
         end
         7'b0010011: begin
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               w_word  = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, opcode};
               w_legal = w_imm_sh_ok;
            end else begin
               w_word  = {imm[11:0], rs1, funct3, rd, opcode};
               w_legal = w_imm_i_ok;
            end
         end
         7'b0000011, 7'b1100111: begin
            w_word  = {imm[11:0], rs1, funct3, rd, opcode};
            w_legal = w_imm_i_ok;
         end
         7'b0100011: begin
            w_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            w_legal = w_imm_i_ok;
         end
         7'b1100011: begin
            w_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            w_legal = w_imm_b_ok;
         end
         7'b0110111, 7'b0010111: begin
            w_word  = {imm[31:12], rd, opcode};
            w_legal = w_imm_u_ok;
         end
         7'b1101111: begin
            w_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            w_legal = w_imm_j_ok;
         end
         default: begin
            w_word  = 32'h0;
            w_legal = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // Handshake and loader state
   // ---------------------------------------------------------------------------------------
   // Refuse a new word while the write that fills the last slot is completing, so nothing
   // is ever consumed beyond DEPTH.
   assign w_last_slot = (r_count == CW'(DEPTH - 1));
   assign in_ready    = !reset && !restart && (r_state == StLoad) &&
                        (!r_wr_valid || (mem_ready && !w_last_slot));
   assign w_accept    = in_valid && in_ready;
   assign w_wr_done   = r_wr_valid && mem_ready;

   always_comb begin
      w_state_nxt    = r_state;
      w_wr_valid_nxt = r_wr_valid;
      w_wr_data_nxt  = r_wr_data;
      w_addr_nxt     = r_addr;
      w_count_nxt    = r_count;
      w_err_nxt      = 1'b0;
      if (restart) begin
         w_state_nxt    = StLoad;
         w_wr_valid_nxt = 1'b0;
         w_wr_data_nxt  = 32'h0;
         w_addr_nxt     = BASE_ADDR;
         w_count_nxt    = '0;
      end else begin
         if (w_wr_done) begin
            w_wr_valid_nxt = 1'b0;
            w_addr_nxt     = r_addr + 32'd4;
            w_count_nxt    = r_count + 1'b1;
            if (w_last_slot) begin
               w_state_nxt = StFull;
            end
         end
         if (w_accept) begin
            if (w_legal) begin
               w_wr_valid_nxt = 1'b1;
               w_wr_data_nxt  = w_word;
            end else begin
               w_err_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= StLoad;
         r_wr_valid <= 1'b0;
         r_wr_data  <= 32'h0;
         r_addr     <= BASE_ADDR;
         r_count    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wr_valid <= w_wr_valid_nxt;
         r_wr_data  <= w_wr_data_nxt;
         r_addr     <= w_addr_nxt;
         r_count    <= w_count_nxt;
         r_err      <= w_err_nxt;
      end
   end

   assign wr_valid = r_wr_valid;
   assign wr_data  = r_wr_data;
   assign wr_addr  = r_addr;
   assign err      = r_err;
   assign done     = (r_state == StFull);
   assign count    = r_count;

endmodule
